// File: rtl/cond_unit.sv
// cond_unit: ARM-style condition evaluation against a registered NZCV flag set.
// It gates the PC, register and memory write requests with the condition
// result, updates the flags when the instruction executes, and keeps
// saturating counters of executed and skipped instructions.
module cond_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        InstrValid,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    input  logic        NoWrite,
    input  logic        Stall,
    input  logic        Flush,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        CondEx,
    output logic        Undef,
    output logic [3:0]  Flags,
    output logic [15:0] ExecCount,
    output logic [15:0] SkipCount
);

    logic [3:0]  flags_r;
    logic [15:0] exec_r;
    logic [15:0] skip_r;
    logic        cond_ex_s;
    logic        go_s;
    logic        count_en_s;

    // Evaluate one ARM condition code against {N,Z,C,V}; 1111 never passes.
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Increment a counter but stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        logic [15:0] r;
        if (val == 16'hFFFF) begin
            r = val;
        end else begin
            r = val + 16'd1;
        end
        return r;
    endfunction

    // Condition result, execute qualifier and the gated write enables.
    always_comb begin
        cond_ex_s  = eval_cond(Cond, flags_r);
        go_s       = cond_ex_s & InstrValid & ~Flush;
        count_en_s = InstrValid & ~Flush & ~Stall;
        CondEx     = cond_ex_s;
        PCSrc      = PCS & go_s;
        RegWrite   = RegW & go_s & ~NoWrite;
        MemWrite   = MemW & go_s;
        Undef      = InstrValid & (Cond == 4'b1111);
    end

    // Flag register: each half written independently by an executing instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else if (go_s && !Stall) begin
            if (FlagW[1]) begin
                flags_r[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                flags_r[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Executed/skipped counters: exactly one advances per real, unflushed, unstalled instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_r <= 16'h0000;
            skip_r <= 16'h0000;
        end else if (count_en_s) begin
            if (cond_ex_s) begin
                exec_r <= sat_inc(exec_r);
            end else begin
                skip_r <= sat_inc(skip_r);
            end
        end
    end

    assign Flags     = flags_r;
    assign ExecCount = exec_r;
    assign SkipCount = skip_r;

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Cond  input  4  ARM condition field of the current instruction (instr[31:28]).
REQ-005 ALUFlags  input  4  ALU flags {N,Z,C,V}: bit3 N, bit2 Z, bit1 C, bit0 V.
REQ-006 FlagW  input  2  flag write enables: bit1 selects N,Z; bit0 selects C,V.
REQ-007 InstrValid  input  1  current instruction is real (not a bubble).
REQ-008 PCS, RegW, MemW  input  1 each  raw decoder requests for PC write, register write and memory write.
REQ-009 NoWrite  input  1  suppress the register write (CMP/TST class).
REQ-010 Stall  input  1  hold all state this cycle.
REQ-011 Flush  input  1  squash the current instruction.
REQ-012 PCSrc, RegWrite, MemWrite  output  1 each  gated write enables.
REQ-013 CondEx  output  1  condition passed.
REQ-014 Undef  output  1  Cond = 4'b1111 with InstrValid high.
REQ-015 Flags  output  4  registered flags {N,Z,C,V}.
REQ-016 ExecCount, SkipCount  output  16 each  saturating count of executed and skipped instructions.

Function
REQ-017 CondEx SHALL be combinational from Cond and registered Flags:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z.
- GE N==V; LT N!=V.
- GT !Z&(N==V); LE Z|(N!=V).
- AL 1; 1111 gives 0.
REQ-018 A qualifier Go SHALL equal CondEx & InstrValid & !Flush.
REQ-019 Gated outputs SHALL be: PCSrc = PCS&Go; RegWrite = RegW&Go&!NoWrite; MemWrite = MemW&Go.
- All three are combinational, with zero-cycle latency.
- Stall does not gate them; the pipeline holds its inputs stable while stalled.
REQ-020 On a clock edge with Go & !Stall, the block SHALL update flags as follows:
- Flags[3:2] <= ALUFlags[3:2] when FlagW[1].
- Flags[1:0] <= ALUFlags[1:0] when FlagW[0].
- Each half updates independently.
REQ-021 Flags SHALL NOT change when Go is 0 or Stall is 1.
- This covers failed conditions, bubbles, flushed instructions and Cond=1111.
REQ-022 A flag update SHALL become visible to CondEx from the next cycle only.
- There is no same-cycle bypass from ALUFlags to CondEx.
REQ-023 On each edge with InstrValid & !Flush & !Stall, one counter SHALL increment:
- ExecCount increments when CondEx is 1.
- SkipCount increments when CondEx is 0; this includes Cond=1111.
REQ-024 Each counter SHALL saturate at 16'hFFFF and never wrap.
REQ-025 Undef SHALL be combinational and SHALL NOT be masked by Flush.
REQ-026 When Stall and Flush are both 1, Flush SHALL gate the outputs and Stall SHALL hold all state.

Reset
REQ-027 When reset is 1 at a clock edge, the block SHALL set Flags=4'b0000 and ExecCount=SkipCount=0, regardless of Stall, Flush or FlagW.
REQ-028 Reset SHALL take priority over every same-edge update.
- Reset asserted mid-instruction discards that instruction's flag write and count.
REQ-029 During and after reset, combinational outputs SHALL follow REQ-017 to REQ-019 using Flags=0000.
- With Flags=0000, EQ fails, NE passes and AL passes.

Verification
REQ-030 Sequence Cond=1110 (AL), FlagW=11, ALUFlags=0100, InstrValid=1, then Cond=0000 (EQ), RegW=1 -> Flags=0100 and EQ gives CondEx=1, RegWrite=1; ExecCount=2.
REQ-031 Flags=0100, Cond=0000, FlagW=11, ALUFlags=1000 -> CondEx=1, Flags become 1000 next cycle; a following EQ gives CondEx=0, all gated writes 0, SkipCount+1, Flags remain 1000.
REQ-032 Partial write: Flags=1111, FlagW=01, ALUFlags=0000, AL -> Flags=1100; then FlagW=10 -> Flags=0000.
REQ-033 Full signed/unsigned sweep: for all 16 Flags values x 15 Cond codes (excluding 1111), CondEx matches the REQ-017 table.
- Cond=1111 gives CondEx=0, Undef=1 and SkipCount increments.
REQ-034 Stall=1 with AL, FlagW=11, ALUFlags=1111 for 3 cycles -> Flags and counters unchanged, while RegWrite follows RegW.
- Flush=1 -> all gated outputs 0, with no count and no flag change.
REQ-035 Preload ExecCount=16'hFFFE by stimulus, then 3 passing instructions -> count holds at 16'hFFFF.
- reset -> Flags=0000 and both counters 0 on the next edge.
